// File: rtl/load_store_unit_if.sv
// Bus bundle between the load/store unit, the core execute stage and data memory.
// The master modport is the LSU itself; the slave modport is everything around it.
interface load_store_unit_if;
  // Core request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // Core response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  // Data-memory channel
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_write_byte;
  logic        data_write_valid;
  logic        data_read_valid;
  logic [31:0] data_read;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  resp_ready,
    input  data_read,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    output data_addr, data_write, data_write_byte, data_write_valid, data_read_valid
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output resp_ready,
    output data_read,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    input  data_addr, data_write, data_write_byte, data_write_valid, data_read_valid
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request in flight, lane-aligned memory access,
// load extraction with sign/zero extension, error response for illegal or misaligned ops.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0] LAST_READ = 4'(READ_LATENCY - 1);

  logic [1:0]  state, state_n;
  logic [3:0]  count, count_n;

  // Operation latched at acceptance; only the low address bits matter after that
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_offset;

  logic        ready;
  logic        accept;

  logic [31:0] data_addr, data_addr_n;
  logic [31:0] data_write, data_write_n;
  logic [3:0]  data_write_byte, data_write_byte_n;
  logic        write_valid, write_valid_n;
  logic        read_valid, read_valid_n;
  logic        resp_valid, resp_valid_n;
  logic [31:0] resp_rdata, resp_rdata_n;
  logic        resp_error, resp_error_n;

  function automatic logic is_bad(input logic store, input logic [2:0] funct3,
                                  input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    illegal    = store ? (funct3 > 3'b010) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && offset[0]) ||
                 (funct3[1:0] == 2'b10 && offset != 2'b00);
    return illegal || misaligned;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    unique case (size)
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [3:0] store_enables(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] enables;
    unique case (size)
      2'b00:   enables = 4'b0001 << offset;
      2'b01:   enables = 4'b0011 << offset;
      default: enables = 4'b1111;
    endcase
    return enables;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] funct3, input logic [1:0] offset,
                                          input logic [31:0] word);
    logic [31:0] raw;
    logic [31:0] value;
    raw = word >> {offset, 3'b000};
    unique case (funct3)
      3'b000:  value = {{24{raw[7]}}, raw[7:0]};
      3'b100:  value = {24'h0, raw[7:0]};
      3'b001:  value = {{16{raw[15]}}, raw[15:0]};
      3'b101:  value = {16'h0, raw[15:0]};
      default: value = raw;
    endcase
    return value;
  endfunction

  // req_ready is the only combinational output so a request can be taken in the first IDLE cycle
  assign ready  = (state == IDLE) && reset;
  assign accept = bus.req_valid && ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_n           = state;
    count_n           = count;
    data_addr_n       = data_addr;
    data_write_n      = data_write;
    data_write_byte_n = data_write_byte;
    write_valid_n     = 1'b0;
    read_valid_n      = 1'b0;
    resp_valid_n      = resp_valid;
    resp_rdata_n      = resp_rdata;
    resp_error_n      = resp_error;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_bad(bus.req_store, bus.req_funct3, bus.req_addr[1:0])) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_error_n = 1'b1;
            resp_rdata_n = 32'h0;
          end else begin
            state_n     = ACCESS;
            data_addr_n = {bus.req_addr[31:2], 2'b00};
            if (bus.req_store) begin
              data_write_n      = store_lanes(bus.req_funct3[1:0], bus.req_wdata);
              data_write_byte_n = store_enables(bus.req_funct3[1:0], bus.req_addr[1:0]);
              write_valid_n     = 1'b1;
            end else begin
              data_write_n      = 32'h0;
              data_write_byte_n = 4'h0;
              read_valid_n      = 1'b1;
              count_n           = 4'h0;
            end
          end
        end
      end

      ACCESS, WAIT: begin
        if (op_store || count == LAST_READ) begin
          // Store strobe lasted its single cycle, or the last read cycle ends here
          state_n           = RESP;
          data_addr_n       = 32'h0;
          data_write_n      = 32'h0;
          data_write_byte_n = 4'h0;
          resp_valid_n      = 1'b1;
          resp_error_n      = 1'b0;
          resp_rdata_n      = op_store ? 32'h0 : extract(op_funct3, op_offset, bus.data_read);
        end else begin
          state_n      = WAIT;
          count_n      = count + 4'd1;
          read_valid_n = 1'b1;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          resp_rdata_n = 32'h0;
          resp_error_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      count           <= 4'h0;
      op_store        <= 1'b0;
      op_funct3       <= 3'h0;
      op_offset       <= 2'h0;
      data_addr       <= 32'h0;
      data_write      <= 32'h0;
      data_write_byte <= 4'h0;
      write_valid     <= 1'b0;
      read_valid      <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_error      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_n;
      count           <= count_n;
      data_addr       <= data_addr_n;
      data_write      <= data_write_n;
      data_write_byte <= data_write_byte_n;
      write_valid     <= write_valid_n;
      read_valid      <= read_valid_n;
      resp_valid      <= resp_valid_n;
      resp_rdata      <= resp_rdata_n;
      resp_error      <= resp_error_n;
      if (accept) begin
        op_store  <= bus.req_store;
        op_funct3 <= bus.req_funct3;
        op_offset <= bus.req_addr[1:0];
      end
    end
  end

  assign bus.req_ready        = ready;
  assign bus.resp_valid       = resp_valid;
  assign bus.resp_rdata       = resp_rdata;
  assign bus.resp_error       = resp_error;
  assign bus.data_addr        = data_addr;
  assign bus.data_write       = data_write;
  assign bus.data_write_byte  = data_write_byte;
  assign bus.data_write_valid = write_valid;
  assign bus.data_read_valid  = read_valid;

  strobes_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(write_valid && read_valid));

  response_stable: assert property (@(posedge clk) disable iff (!reset)
    resp_valid && !bus.resp_ready |=> resp_valid && $stable(resp_rdata) && $stable(resp_error));

  no_bus_while_responding: assert property (@(posedge clk) disable iff (!reset)
    resp_valid |-> !write_valid && !read_valid);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory model
// and a reference model that predicts bus writes, read addresses and responses.
module tb_load_store_unit;

  localparam int RL = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];

  logic [7:0] ref_mem[64];
  logic [7:0] mem[64];

  int cyc = 0;
  int rv_cnt = 0;
  int rr_mode = 0;
  logic [5:0] rd_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: data is only valid on the last read-strobe cycle, garbage before that
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_cnt <= 0;
    end else begin
      rv_cnt <= bus.data_read_valid ? rv_cnt + 1 : 0;
      if (bus.data_write_valid)
        for (int k = 0; k < 4; k++)
          if (bus.data_write_byte[k]) mem[{bus.data_addr[5:2], 2'b00} + 6'(k)] <= bus.data_write[8*k +: 8];
    end
  end

  always_comb begin
    rd_base       = {bus.data_addr[5:2], 2'b00};
    bus.data_read = 32'hDEAD_BEEF;
    if (bus.data_read_valid && rv_cnt == RL - 1)
      bus.data_read = {mem[rd_base + 6'd3], mem[rd_base + 6'd2], mem[rd_base + 6'd1], mem[rd_base]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // resp_ready: 0 = always ready, 1 = random back-pressure, 2 = held low
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = 1'b1;
        1:       bus.resp_ready = ($urandom % 3) != 0;
        default: bus.resp_ready = 1'b0;
      endcase
    end
  end

  // Reference model: byte-addressed memory and RV32I size/sign rules
  task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    int          n;
    int          base;
    int          off;
    bit          illegal;
    bit          mis;
    logic [31:0] v;
    resp_t       r;
    wr_t         w;
    n       = 1 << f3[1:0];
    off     = int'(a[1:0]);
    base    = int'(a[5:0]);
    illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis     = (int'(a[2:0]) % n) != 0;
    if (illegal || mis) begin
      r = '{rdata: 32'h0, err: 1'b1, lat: 1};
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
      w.addr = a - 32'(off);
      for (int k = 0; k < 4; k++) begin
        w.be[k]         = (k >= off) && (k < off + n);
        w.data[8*k +: 8] = wd[8*(k % n) +: 8];
      end
      wr_q.push_back(w);
      r = '{rdata: 32'h0, err: 1'b0, lat: 2};
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
      if (!f3[2] && n < 4 && v[8*n - 1])
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      rd_q.push_back(a - 32'(off));
      r = '{rdata: v, err: 1'b0, lat: 1 + RL};
    end
    resp_q.push_back(r);
  endtask

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    int n;
    predict(st, f3, a, wd);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(negedge clk);
    for (n = 0; n < 400 && !bus.req_ready; n++) @(negedge clk);
    check("req_accepted", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.req_ready && resp_q.size() == 0 && !bus.resp_valid) break;
    end
    check("drained", resp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {bus.req_ready, bus.resp_valid, bus.resp_error, bus.data_write_valid,
                            bus.data_read_valid, bus.data_write_byte}, 0);
    check({name, "_data"}, {bus.resp_rdata, bus.data_addr}, 0);
    check({name, "_wdata"}, bus.data_write, 0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a response or a bus strobe
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;
  int          rd_len = 0;
  int          acc_cyc = 0;
  logic [31:0] cur_rd;
  resp_t       mon_resp;
  wr_t         mon_wr;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        rd_len     = 0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc + 1;

        if (prev_stall)
          check("resp_held", {bus.resp_valid, bus.resp_error, bus.resp_rdata},
                {1'b1, prev_err, prev_rdata});
        if (bus.resp_valid && !prev_valid) begin
          check("resp_expected", resp_q.size() != 0, 1'b1);
          if (resp_q.size() != 0)
            check("resp_latency", cyc, acc_cyc + resp_q[0].lat - 1);
        end
        if (bus.resp_valid && bus.resp_ready) begin
          check("resp_expected", resp_q.size() != 0, 1'b1);
          if (resp_q.size() != 0) begin
            mon_resp = resp_q.pop_front();
            check("resp_rdata", bus.resp_rdata, mon_resp.rdata);
            check("resp_error", bus.resp_error, mon_resp.err);
          end
        end
        prev_valid = bus.resp_valid;
        prev_stall = bus.resp_valid && !bus.resp_ready;
        prev_rdata = bus.resp_rdata;
        prev_err   = bus.resp_error;

        if (bus.data_write_valid) begin
          check("strobes_exclusive", bus.data_read_valid, 1'b0);
          check("write_expected", wr_q.size() != 0, 1'b1);
          if (wr_q.size() != 0) begin
            mon_wr = wr_q.pop_front();
            check("write_addr", bus.data_addr, mon_wr.addr);
            check("write_data", bus.data_write, mon_wr.data);
            check("write_byte_en", bus.data_write_byte, mon_wr.be);
          end
        end

        if (bus.data_read_valid) begin
          if (rd_len == 0) begin
            check("read_expected", rd_q.size() != 0, 1'b1);
            cur_rd = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
          end
          check("read_addr", bus.data_addr, cur_rd);
          check("read_byte_en", bus.data_write_byte, 4'h0);
          rd_len++;
        end else if (rd_len != 0) begin
          check("read_cycles", rd_len, RL);
          rd_len = 0;
        end
      end
    end
  end

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          n;

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'(i * 37 + 11);
      mem[i]     = 8'(i * 37 + 11);
    end
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'h0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Directed cases
    send(1'b1, 3'b010, 32'h8, 32'h1234_5678);
    send(1'b0, 3'b010, 32'h8, 32'h0);
    send(1'b1, 3'b000, 32'h5, 32'h1234_56AB);
    send(1'b0, 3'b000, 32'h5, 32'h0);
    send(1'b0, 3'b100, 32'h5, 32'h0);
    send(1'b1, 3'b001, 32'h6, 32'hFFFF_8001);
    send(1'b0, 3'b001, 32'h6, 32'h0);
    send(1'b0, 3'b101, 32'h6, 32'h0);
    send(1'b0, 3'b010, 32'h2, 32'h0);
    send(1'b0, 3'b001, 32'h3, 32'h0);
    send(1'b0, 3'b011, 32'h0, 32'h0);
    send(1'b1, 3'b011, 32'h10, 32'h5555_AAAA);
    send(1'b1, 3'b010, 32'hF000_0024, 32'hCAFE_F00D);
    send(1'b0, 3'b100, 32'h0000_0027, 32'h0);
    wait_idle();

    // Back-pressure: response must hold with no new acceptance and no bus activity
    rr_mode = 2;
    send(1'b0, 3'b010, 32'h8, 32'h0);
    for (n = 0; n < 50 && !bus.resp_valid; n++) @(negedge clk);
    check("stall_resp_seen", bus.resp_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("stall_req_ready", bus.req_ready, 1'b0);
      check("stall_resp_valid", bus.resp_valid, 1'b1);
      check("stall_no_bus", {bus.data_write_valid, bus.data_read_valid}, 2'b00);
    end
    rr_mode = 0;
    wait_idle();

    // Reset while a load is waiting on memory
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    rd_q.push_back(32'h10);
    @(negedge clk);
    check("pre_reset_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 check("pre_reset_reading", bus.data_read_valid, 1'b1);
    reset = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", bus.req_ready, 1'b1);
    repeat (10) @(negedge clk);
    check("no_stale_resp", bus.resp_valid, 1'b0);

    // Randomized traffic with random back-pressure
    rr_mode = 1;
    for (int it = 0; it < 200; it++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      st = 1'($urandom);
      if ($urandom % 8 == 0) begin
        f3 = 3'($urandom);
      end else if (st) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      a = $urandom;
      if ($urandom % 4 != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      send(st, f3, a, $urandom);
    end
    rr_mode = 0;
    wait_idle();
    check("writes_drained", wr_q.size(), 0);
    check("reads_drained", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
